// File: rtl/cnt5_step_decoder.sv
// Receive-side decoder for the mod-5 up/down count code: classifies each sampled
// transition, accumulates a signed position and latches a fault after repeated bad samples.
module cnt5_step_decoder #(
    parameter int unsigned POS_W   = 8,
    parameter int unsigned ERR_MAX = 3
) (
    input  logic             clk,
    input  logic             rb,
    input  logic             in_vld,
    input  logic [2:0]       cnt_in,
    input  logic             clr_err,
    output logic             step_up,
    output logic             step_dn,
    output logic             step_bad,
    output logic [POS_W-1:0] pos,
    output logic             locked,
    output logic             err
);

    localparam int unsigned CntW = $clog2(ERR_MAX + 1);
    localparam logic [CntW-1:0] BadLast = CntW'(ERR_MAX - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [POS_W-1:0] PosOne = POS_W'(1);

    typedef enum logic [1:0] {StSeed, StTrack, StFault} state_e;

    state_e            state_q, state_d;
    logic [2:0]        prev_q, prev_d;
    logic [CntW-1:0]   bad_cnt_q, bad_cnt_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              up_q, up_d;
    logic              dn_q, dn_d;
    logic              bad_q, bad_d;

    logic       code_legal;
    logic [2:0] code_up;
    logic [2:0] code_dn;
    logic       bad_inc;

    assign code_legal = (cnt_in <= 3'd4);
    assign code_up    = (prev_q == 3'd4) ? 3'd0 : prev_q + 3'd1;
    assign code_dn    = (prev_q == 3'd0) ? 3'd4 : prev_q - 3'd1;

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        bad_cnt_d = bad_cnt_q;
        pos_d     = pos_q;
        up_d      = 1'b0;
        dn_d      = 1'b0;
        bad_d     = 1'b0;
        bad_inc   = 1'b0;

        unique case (state_q)
            StSeed: begin
                if (in_vld) begin
                    if (code_legal) begin
                        prev_d    = cnt_in;
                        bad_cnt_d = '0;
                        state_d   = StTrack;
                    end else begin
                        bad_d   = 1'b1;
                        bad_inc = 1'b1;
                    end
                end
            end
            StTrack: begin
                if (in_vld) begin
                    if (!code_legal) begin
                        bad_d   = 1'b1;
                        bad_inc = 1'b1;
                    end else if (cnt_in == prev_q) begin
                        bad_cnt_d = '0;
                    end else if (cnt_in == code_up) begin
                        up_d      = 1'b1;
                        pos_d     = pos_q + PosOne;
                        prev_d    = cnt_in;
                        bad_cnt_d = '0;
                    end else if (cnt_in == code_dn) begin
                        dn_d      = 1'b1;
                        pos_d     = pos_q - PosOne;
                        prev_d    = cnt_in;
                        bad_cnt_d = '0;
                    end else begin
                        // Skip of two: resync the reference to the new code.
                        bad_d   = 1'b1;
                        prev_d  = cnt_in;
                        bad_inc = 1'b1;
                    end
                end
            end
            StFault: begin
                if (clr_err) begin
                    state_d   = StSeed;
                    bad_cnt_d = '0;
                end
            end
            default: state_d = StSeed;
        endcase

        if (bad_inc) begin
            bad_cnt_d = bad_cnt_q + CntOne;
            if (bad_cnt_q == BadLast) begin
                state_d = StFault;
            end
        end

        // A clear coincident with a sample wins over escalation on that edge.
        if (clr_err && (state_q != StFault)) begin
            bad_cnt_d = '0;
            if (state_d == StFault) begin
                state_d = state_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rb) begin
            state_q   <= StSeed;
            prev_q    <= 3'd0;
            bad_cnt_q <= '0;
            pos_q     <= '0;
            up_q      <= 1'b0;
            dn_q      <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            bad_cnt_q <= bad_cnt_d;
            pos_q     <= pos_d;
            up_q      <= up_d;
            dn_q      <= dn_d;
            bad_q     <= bad_d;
        end
    end

    assign step_up  = up_q;
    assign step_dn  = dn_q;
    assign step_bad = bad_q;
    assign pos      = pos_q;
    assign locked   = (state_q == StTrack);
    assign err      = (state_q == StFault);

endmodule

// File: tb/tb_cnt5_step_decoder.sv
// Self-checking bench for cnt5_step_decoder: reference model feeds a scoreboard queue,
// scenario tasks add directed checks.
module tb_cnt5_step_decoder;

    localparam int unsigned POS_W   = 8;
    localparam int unsigned ERR_MAX = 3;

    logic             clk;
    logic             rb;
    logic             in_vld;
    logic [2:0]       cnt_in;
    logic             clr_err;
    logic             step_up;
    logic             step_dn;
    logic             step_bad;
    logic [POS_W-1:0] pos;
    logic             locked;
    logic             err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic             up;
        logic             dn;
        logic             bad;
        logic             locked;
        logic             err;
        logic [POS_W-1:0] pos;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: 0 = seed, 1 = track, 2 = fault
    int               m_state = 0;
    int               m_prev  = 0;
    int               m_bad   = 0;
    logic [POS_W-1:0] m_pos   = '0;

    cnt5_step_decoder #(
        .POS_W   (POS_W),
        .ERR_MAX (ERR_MAX)
    ) dut (
        .clk      (clk),
        .rb       (rb),
        .in_vld   (in_vld),
        .cnt_in   (cnt_in),
        .clr_err  (clr_err),
        .step_up  (step_up),
        .step_dn  (step_dn),
        .step_bad (step_bad),
        .pos      (pos),
        .locked   (locked),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if ({step_up, step_dn, step_bad, locked, err, pos} !== mon_e) begin
                errors++;
                $display("FAIL scoreboard t=%0t: got up=%b dn=%b bad=%b lk=%b err=%b pos=%h, want up=%b dn=%b bad=%b lk=%b err=%b pos=%h",
                         $time, step_up, step_dn, step_bad, locked, err, pos,
                         mon_e.up, mon_e.dn, mon_e.bad, mon_e.locked, mon_e.err, mon_e.pos);
            end
        end
    end

    task automatic model_step(input logic r, input logic v, input int c, input logic ce);
        exp_t e;
        int   old_state;
        logic inc;
        e   = '0;
        inc = 1'b0;
        if (r) begin
            m_state = 0;
            m_prev  = 0;
            m_bad   = 0;
            m_pos   = '0;
        end else begin
            old_state = m_state;
            if (m_state == 0) begin
                if (v) begin
                    if (c <= 4) begin
                        m_prev  = c;
                        m_bad   = 0;
                        m_state = 1;
                    end else begin
                        e.bad = 1'b1;
                        inc   = 1'b1;
                    end
                end
            end else if (m_state == 1) begin
                if (v) begin
                    if (c > 4) begin
                        e.bad = 1'b1;
                        inc   = 1'b1;
                    end else if (c == m_prev) begin
                        m_bad = 0;
                    end else if (c == (m_prev + 1) % 5) begin
                        e.up   = 1'b1;
                        m_pos  = m_pos + 1'b1;
                        m_prev = c;
                        m_bad  = 0;
                    end else if (c == (m_prev + 4) % 5) begin
                        e.dn   = 1'b1;
                        m_pos  = m_pos - 1'b1;
                        m_prev = c;
                        m_bad  = 0;
                    end else begin
                        e.bad  = 1'b1;
                        m_prev = c;
                        inc    = 1'b1;
                    end
                end
            end else if (ce) begin
                m_state = 0;
                m_bad   = 0;
            end
            if (inc) begin
                m_bad = m_bad + 1;
                if (m_bad == ERR_MAX) m_state = 2;
            end
            if (ce && old_state != 2) begin
                m_bad   = 0;
                m_state = old_state;
            end
        end
        e.pos    = m_pos;
        e.locked = (m_state == 1);
        e.err    = (m_state == 2);
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic r, input logic v, input int c, input logic ce);
        rb      = r;
        in_vld  = v;
        cnt_in  = c[2:0];
        clr_err = ce;
        model_step(r, v, c, ce);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({step_up, step_dn, step_bad, locked, err, pos} !== 13'd0) begin
            errors++;
            $display("FAIL reset_state: got up=%b dn=%b bad=%b lk=%b err=%b pos=%h, want all 0",
                     step_up, step_dn, step_bad, locked, err, pos);
        end
        cycle(1'b0, 1'b1, 0, 1'b0);
        checks++;
        if (locked !== 1'b1 || pos !== 8'h00 || step_up !== 1'b0) begin
            errors++;
            $display("FAIL seed_lock: got lk=%b pos=%h up=%b, want lk=1 pos=00 up=0",
                     locked, pos, step_up);
        end
    endtask

    task automatic test_up_wrap();
        int codes[6] = '{1, 2, 3, 4, 0, 1};
        int ups = 0;
        do_reset();
        cycle(1'b0, 1'b1, 0, 1'b0);
        foreach (codes[i]) begin
            cycle(1'b0, 1'b1, codes[i], 1'b0);
            if (step_up === 1'b1 && step_dn === 1'b0 && step_bad === 1'b0) ups++;
        end
        checks++;
        if (ups != 6 || pos !== 8'd6) begin
            errors++;
            $display("FAIL up_wrap: got ups=%0d pos=%h, want ups=6 pos=06", ups, pos);
        end
    endtask

    task automatic test_down_wrap();
        do_reset();
        cycle(1'b0, 1'b1, 0, 1'b0);
        cycle(1'b0, 1'b1, 4, 1'b0);
        checks++;
        if (step_dn !== 1'b1 || pos !== 8'hFF) begin
            errors++;
            $display("FAIL down_wrap_0to4: got dn=%b pos=%h, want dn=1 pos=ff", step_dn, pos);
        end
        cycle(1'b0, 1'b1, 3, 1'b0);
        cycle(1'b0, 1'b1, 3, 1'b0);
        checks++;
        if ({step_up, step_dn, step_bad} !== 3'b000 || pos !== 8'hFE) begin
            errors++;
            $display("FAIL hold: got pulses=%b pos=%h, want pulses=000 pos=fe",
                     {step_up, step_dn, step_bad}, pos);
        end
    endtask

    task automatic test_skip_illegal();
        do_reset();
        cycle(1'b0, 1'b1, 1, 1'b0);
        cycle(1'b0, 1'b1, 3, 1'b0);
        checks++;
        if (step_bad !== 1'b1 || pos !== 8'h00 || locked !== 1'b1) begin
            errors++;
            $display("FAIL skip_bad: got bad=%b pos=%h lk=%b, want bad=1 pos=00 lk=1",
                     step_bad, pos, locked);
        end
        cycle(1'b0, 1'b1, 4, 1'b0);
        checks++;
        if (step_up !== 1'b1 || pos !== 8'h01) begin
            errors++;
            $display("FAIL skip_resync: got up=%b pos=%h, want up=1 pos=01", step_up, pos);
        end
        cycle(1'b0, 1'b1, 6, 1'b0);
        cycle(1'b0, 1'b1, 0, 1'b0);
        checks++;
        if (step_up !== 1'b1 || pos !== 8'h02) begin
            errors++;
            $display("FAIL illegal_keep_prev: got up=%b pos=%h, want up=1 pos=02", step_up, pos);
        end
    endtask

    task automatic test_fault();
        do_reset();
        cycle(1'b0, 1'b1, 0, 1'b0);
        cycle(1'b0, 1'b1, 1, 1'b0);
        cycle(1'b0, 1'b1, 2, 1'b0);
        cycle(1'b0, 1'b1, 7, 1'b0);
        cycle(1'b0, 1'b1, 7, 1'b0);
        checks++;
        if (err !== 1'b0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL fault_early: got err=%b lk=%b, want err=0 lk=1", err, locked);
        end
        cycle(1'b0, 1'b1, 7, 1'b0);
        checks++;
        if (step_bad !== 1'b1 || err !== 1'b1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL fault_enter: got bad=%b err=%b lk=%b, want bad=1 err=1 lk=0",
                     step_bad, err, locked);
        end
        cycle(1'b0, 1'b1, 3, 1'b0);
        checks++;
        if ({step_up, step_dn, step_bad} !== 3'b000 || pos !== 8'h02 || err !== 1'b1) begin
            errors++;
            $display("FAIL fault_ignore: got pulses=%b pos=%h err=%b, want 000 02 1",
                     {step_up, step_dn, step_bad}, pos, err);
        end
        cycle(1'b0, 1'b0, 0, 1'b1);
        checks++;
        if (err !== 1'b0 || locked !== 1'b0 || pos !== 8'h02) begin
            errors++;
            $display("FAIL fault_clear: got err=%b lk=%b pos=%h, want err=0 lk=0 pos=02",
                     err, locked, pos);
        end
        cycle(1'b0, 1'b1, 2, 1'b0);
        cycle(1'b0, 1'b1, 7, 1'b0);
        cycle(1'b0, 1'b1, 7, 1'b1);
        cycle(1'b0, 1'b1, 7, 1'b0);
        checks++;
        if (err !== 1'b0 || locked !== 1'b1 || step_bad !== 1'b1) begin
            errors++;
            $display("FAIL clr_coincident: got err=%b lk=%b bad=%b, want err=0 lk=1 bad=1",
                     err, locked, step_bad);
        end
        do_reset();
        cycle(1'b0, 1'b1, 5, 1'b0);
        cycle(1'b0, 1'b1, 6, 1'b0);
        cycle(1'b0, 1'b1, 7, 1'b0);
        checks++;
        if (err !== 1'b1 || step_bad !== 1'b1) begin
            errors++;
            $display("FAIL seed_fault: got err=%b bad=%b, want err=1 bad=1", err, step_bad);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        cycle(1'b0, 1'b1, 0, 1'b0);
        for (int i = 1; i <= 127; i++) cycle(1'b0, 1'b1, i % 5, 1'b0);
        checks++;
        if (pos !== 8'h7F) begin
            errors++;
            $display("FAIL pos_127: got pos=%h, want 7f", pos);
        end
        cycle(1'b0, 1'b1, 128 % 5, 1'b0);
        checks++;
        if (pos !== 8'h80 || step_up !== 1'b1) begin
            errors++;
            $display("FAIL pos_wrap: got pos=%h up=%b, want pos=80 up=1", pos, step_up);
        end
        cycle(1'b0, 1'b0, 0, 1'b1);
        checks++;
        if (pos !== 8'h80 || {step_up, step_dn, step_bad} !== 3'b000 || locked !== 1'b1) begin
            errors++;
            $display("FAIL idle_hold: got pos=%h pulses=%b lk=%b, want 80 000 1",
                     pos, {step_up, step_dn, step_bad}, locked);
        end
        cycle(1'b0, 1'b1, 2, 1'b0);
        checks++;
        if (pos !== 8'h7F || step_dn !== 1'b1) begin
            errors++;
            $display("FAIL pos_unwrap: got pos=%h dn=%b, want pos=7f dn=1", pos, step_dn);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(1'b0, 1'b1, 0, 1'b0);
        for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, i % 5, 1'b0);
        checks++;
        if (pos !== 8'h05) begin
            errors++;
            $display("FAIL mid_pos: got pos=%h, want 05", pos);
        end
        cycle(1'b1, 1'b1, 1, 1'b0);
        checks++;
        if ({step_up, step_dn, step_bad, locked, err, pos} !== 13'd0) begin
            errors++;
            $display("FAIL mid_reset: got up=%b dn=%b bad=%b lk=%b err=%b pos=%h, want all 0",
                     step_up, step_dn, step_bad, locked, err, pos);
        end
        cycle(1'b1, 1'b1, 7, 1'b0);
        cycle(1'b0, 1'b1, 3, 1'b0);
        checks++;
        if (locked !== 1'b1 || pos !== 8'h00 || step_bad !== 1'b0) begin
            errors++;
            $display("FAIL mid_reseed: got lk=%b pos=%h bad=%b, want lk=1 pos=00 bad=0",
                     locked, pos, step_bad);
        end
    endtask

    initial begin
        rb      = 1'b1;
        in_vld  = 1'b0;
        cnt_in  = 3'd0;
        clr_err = 1'b0;
        @(negedge clk);
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_skip_illegal();
        test_fault();
        test_overflow();
        test_reset_mid();
        rb     = 1'b0;
        in_vld = 1'b0;
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
